// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - tx_state_e    : shifter FSM state encoding
//   - OFF_*         : register word offsets from the peripheral base address
//   - STAT_*        : bit positions inside the STATUS register
//   - MIN_BAUD_DIV  : smallest clocks-per-bit the shifter will accept
//   - clamp_div()   : applies MIN_BAUD_DIV to a written divisor
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int OFF_TXDATA = 0;
    localparam int OFF_STATUS = 1;
    localparam int OFF_BAUD   = 2;
    localparam int NUM_REGS   = 3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_ACTIVE    = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_MSB = 7;
    localparam int STAT_PARITY_EN = 8;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd2;

    // A divisor of 0 or 1 would leave no room for the bit counter to
    // distinguish "first clock" from "last clock" of a bit, so pin it at 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < MIN_BAUD_DIV) ? MIN_BAUD_DIV : value;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous show-ahead FIFO holding bytes waiting for the shifter.
// pop_data always presents the oldest entry; a push while full is accepted
// only when a pop happens on the same edge (the pop frees the slot).
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset (empties the FIFO)
//   push       in   write push_data on this edge
//   push_data  in   WIDTH-bit entry to store
//   pop        in   discard the oldest entry on this edge
//   pop_data   out  oldest entry (valid while !empty)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   count      out  number of entries stored (0..DEPTH)
//
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define what is valid, so clearing every entry
    // would buy nothing and block mapping onto RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped UART transmitter on the shared CPU/data-memory bus.
// Register window (word offsets from START_ADDRESS):
//   +0 TXDATA   write-only, bus_data[7:0] pushed into the TX FIFO; reads 0
//   +1 STATUS   {bit8 parity feature, [7:4] count, overflow, active,
//                empty, full}; any write clears the sticky overflow
//   +2 BAUD_DIV clocks per bit, read/write, writes below 2 clamp to 2
//
// Ports:
//   clk       in     system clock
//   reset     in     synchronous, active-low reset
//   bus_data  inout  shared data bus, driven only during a decoded read
//   bus_addr  in     bus address
//   read      in     bus read strobe (combinational read, no side effects)
//   write     in     bus write strobe (sampled on rising clk)
//   uart_txd  out    serial output, idle high
//   busy      out    a frame is shifting or the FIFO holds data
//
// Build option: define UART_TX_PARITY_EN to send an even-parity bit
// between the data bits and the stop bit (8E1) and report it in STATUS
// bit 8. Without it the frame is 8N1.
//
// DATA_WIDTH must be at least 16 to carry the full BAUD_DIV value.
// ---------------------------------------------------------------------------
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 20,
    parameter int                    DATA_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS   = 20'h80000,
    parameter int                    FIFO_DEPTH      = 8,
    parameter int                    CLK_DIV_DEFAULT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  read,
    input  logic                  write,
    output logic                  uart_txd,
    output logic                  busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FEATURE = 1'b1;
`else
    localparam logic PARITY_FEATURE = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] offset;
    logic                  hit;
    logic                  sel_txdata;
    logic                  sel_status;
    logic                  sel_baud;
    logic                  wr_txdata;
    logic                  wr_status;
    logic                  wr_baud;

    // Addresses below the base wrap to huge offsets, so one compare
    // covers both sides of the window.
    assign offset     = bus_addr - START_ADDRESS;
    assign hit        = (offset < ADDR_WIDTH'(NUM_REGS));
    assign sel_txdata = hit && (offset == ADDR_WIDTH'(OFF_TXDATA));
    assign sel_status = hit && (offset == ADDR_WIDTH'(OFF_STATUS));
    assign sel_baud   = hit && (offset == ADDR_WIDTH'(OFF_BAUD));
    assign wr_txdata  = write && sel_txdata;
    assign wr_status  = write && sel_status;
    assign wr_baud    = write && sel_baud;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (bus_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [15:0] baud_div;
    logic        overflow;
    logic        overflow_set;

    // A push into a full FIFO is only lost when the shifter is not
    // popping on the same edge.
    assign overflow_set = wr_txdata && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_div <= 16'(CLK_DIV_DEFAULT);
            overflow <= 1'b0;
        end else begin
            if (wr_baud) begin
                baud_div <= clamp_div(bus_data[15:0]);
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (wr_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shifter FSM
    // ------------------------------------------------------------------
    tx_state_e   state;
    tx_state_e   state_nx;
    logic [15:0] div_lat;   // divisor frozen for the frame in flight
    logic [15:0] baud_cnt;  // clocks elapsed within the current bit
    logic [2:0]  bit_idx;   // data bit being sent
    logic [7:0]  tx_byte;
    logic        bit_tick;  // last clock of the current bit

    assign bit_tick = (baud_cnt == div_lat - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nx = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        uart_txd = 1'b1;
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            START:   uart_txd = 1'b0;
            DATA:    uart_txd = tx_byte[bit_idx];
            PARITY:  uart_txd = ^tx_byte;
            STOP:    uart_txd = 1'b1;
            default: uart_txd = 1'b1;
        endcase
    end

    // Bit timing and frame datapath. The byte and divisor are captured on
    // the pop edge, so later BAUD_DIV writes only affect the next frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_lat  <= 16'(CLK_DIV_DEFAULT);
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (fifo_pop) begin
                tx_byte <= fifo_dout;
                div_lat <= baud_div;
            end
        end else if (bit_tick) begin
            baud_cnt <= '0;
            if (state == DATA) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [3:0]            count_disp;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        if (int'(fifo_count) > 15) begin
            count_disp = 4'd15;
        end else begin
            count_disp = 4'(fifo_count);
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_status) begin
            rd_data[STAT_FULL]                      = fifo_full;
            rd_data[STAT_EMPTY]                     = fifo_empty;
            rd_data[STAT_ACTIVE]                    = (state != IDLE);
            rd_data[STAT_OVERFLOW]                  = overflow;
            rd_data[STAT_COUNT_MSB:STAT_COUNT_LSB]  = count_disp;
            rd_data[STAT_PARITY_EN]                 = PARITY_FEATURE;
        end else if (sel_baud) begin
            rd_data[15:0] = baud_div;
        end
    end

    assign bus_data = (read && hit) ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_mmio
// Directed bench for uart_tx_mmio: register reset values, window decode,
// serial frame timing, back-to-back gap, overflow and its clear, push/pop
// on a full FIFO, mid-frame divisor change, clamp, and reset mid-frame.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise 8E1 frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam logic [19:0] BASE = 20'h80000;

`ifdef UART_TX_PARITY_EN
    localparam bit          PAR  = 1'b1;
    localparam logic [15:0] FEAT = 16'h0100;
`else
    localparam bit          PAR  = 1'b0;
    localparam logic [15:0] FEAT = 16'h0000;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [19:0] bus_addr = '0;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic        drv_en   = 1'b0;
    logic [15:0] drv_data = '0;
    tri1  [15:0] bus_data;
    logic        uart_txd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    assign bus_data = drv_en ? drv_data : 16'hzzzz;

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .bus_data (bus_data),
        .bus_addr (bus_addr),
        .read     (read),
        .write    (write),
        .uart_txd (uart_txd),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input int off, input logic [15:0] data);
        @(negedge clk);
        bus_addr = BASE + 20'(off);
        drv_data = data;
        drv_en   = 1'b1;
        write    = 1'b1;
        @(posedge clk);
        #1;
        write  = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] addr, output logic [15:0] data);
        @(negedge clk);
        bus_addr = addr;
        read     = 1'b1;
        #1;
        data = bus_data;
        read = 1'b0;
    endtask

    // Samples one clock per negedge starting at the next negedge, which
    // must be the first clock of the start bit.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int div);
        int   nbits;
        logic e;
        nbits = PAR ? 11 : 10;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)                e = 1'b0;
            else if (i <= 8)           e = b[i-1];
            else if (PAR && (i == 9))  e = ^b;
            else                       e = 1'b1;
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                check($sformatf("%s bit%0d clk%0d", tag, i, c), uart_txd, e);
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        bit          found;

        // ---------------- reset state ----------------
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus_read(BASE + 20'd1, rd);  check("reset status", rd, 16'h0002 | FEAT);
        bus_read(BASE + 20'd2, rd);  check("reset baud", rd, 16'd434);
        check("reset txd", uart_txd, 1'b1);
        check("reset busy", busy, 1'b0);
        bus_read(BASE + 20'd3, rd);  check("above window Z", rd, 16'hFFFF);
        bus_read(BASE - 20'd1, rd);  check("below window Z", rd, 16'hFFFF);
        bus_read(BASE, rd);          check("txdata reads 0", rd, 16'h0000);

        // ---------------- single frame A5 at div 4 ----------------
        bus_write(2, 16'd4);
        bus_read(BASE + 20'd2, rd);  check("baud 4", rd, 16'd4);
        bus_write(0, 16'h00A5);
        check("busy after push", busy, 1'b1);
        @(negedge clk);
        check("txd high before start", uart_txd, 1'b1);
        expect_frame("A5", 8'hA5, 4);
        @(posedge clk);
        #1;
        check("busy after A5", busy, 1'b0);
        check("idle txd after A5", uart_txd, 1'b1);

        // ---------------- overflow at div 2 ----------------
        bus_write(2, 16'd2);
        for (int i = 0; i < 9; i++) begin
            bus_write(0, 16'(8'h30 + i));
        end
        bus_read(BASE + 20'd1, rd);  check("9 writes status", rd, 16'h0085 | FEAT);
        bus_write(0, 16'h0039);
        bus_read(BASE + 20'd1, rd);  check("overflow status", rd, 16'h008D | FEAT);
        bus_write(1, 16'h0000);
        bus_read(BASE + 20'd1, rd);  check("overflow cleared", rd, 16'h0085 | FEAT);

        // Push on the very edge the shifter pops from a full FIFO.
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            bus_addr = BASE + 20'd1;
            read     = 1'b1;
            #1;
            rd   = bus_data;
            read = 1'b0;
            if (!rd[2]) begin
                found    = 1'b1;
                bus_addr = BASE;
                drv_data = 16'h00C3;
                drv_en   = 1'b1;
                write    = 1'b1;
                @(posedge clk);
                #1;
                write  = 1'b0;
                drv_en = 1'b0;
                break;
            end
        end
        check("idle seen while full", found, 1'b1);
        bus_read(BASE + 20'd1, rd);  check("push+pop when full", rd, 16'h0085 | FEAT);
        wait_idle("drain overflow burst", 1000);

        // ---------------- back-to-back frames ----------------
        bus_write(2, 16'd4);
        bus_write(0, 16'h0011);
        bus_write(0, 16'h0022);
        expect_frame("b2b 11", 8'h11, 4);
        @(negedge clk);
        check("b2b gap txd", uart_txd, 1'b1);
        check("b2b gap busy", busy, 1'b1);
        expect_frame("b2b 22", 8'h22, 4);
        wait_idle("b2b idle", 50);

        // ---------------- mid-frame divisor change ----------------
        bus_write(0, 16'h003C);
        bus_write(0, 16'h005A);
        fork
            expect_frame("div4 3C", 8'h3C, 4);
            begin
                repeat (6) @(posedge clk);
                bus_write(2, 16'd8);
            end
        join
        @(negedge clk);
        check("div gap txd", uart_txd, 1'b1);
        expect_frame("div8 5A", 8'h5A, 8);
        wait_idle("div idle", 50);
        bus_read(BASE + 20'd2, rd);  check("baud 8", rd, 16'd8);
        bus_write(2, 16'd1);
        bus_read(BASE + 20'd2, rd);  check("baud clamp 1", rd, 16'd2);
        bus_write(2, 16'd0);
        bus_read(BASE + 20'd2, rd);  check("baud clamp 0", rd, 16'd2);

`ifdef UART_TX_PARITY_EN
        // ---------------- parity frames ----------------
        bus_write(2, 16'd4);
        bus_write(0, 16'h0007);
        @(negedge clk);
        check("par07 pre", uart_txd, 1'b1);
        expect_frame("par 07", 8'h07, 4);
        wait_idle("par07 idle", 20);
        bus_write(0, 16'h0003);
        @(negedge clk);
        check("par03 pre", uart_txd, 1'b1);
        expect_frame("par 03", 8'h03, 4);
        wait_idle("par03 idle", 20);
`endif

        // ---------------- reset mid-frame ----------------
        bus_write(2, 16'd4);
        bus_write(0, 16'h000F);
        bus_write(0, 16'h0077);
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("0F bit4 low", uart_txd, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset aborts txd", uart_txd, 1'b1);
        check("reset aborts busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(BASE + 20'd1, rd);  check("post-reset status", rd, 16'h0002 | FEAT);
        bus_read(BASE + 20'd2, rd);  check("post-reset baud", rd, 16'd434);
        repeat (5) @(negedge clk);
        check("post-reset txd idle", uart_txd, 1'b1);
        check("post-reset not busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter sitting on the shared CPU/data-memory bus, in the peripheral window above data memory.
- Consumes CPU bus writes: bytes are pushed into a small TX FIFO and serialised 8N1 (optionally 8E1) on a pin.
- Exposes status and baud-divisor registers readable over the same tri-state bus_data.

Parameters:
- ADDR_WIDTH, 20, bus address width.
- DATA_WIDTH, 16, bus data width.
- START_ADDRESS, 20'h80000, base address. Occupies 3 consecutive word addresses.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2, ≥2.
- CLK_DIV_DEFAULT, 434, reset value of BAUD_DIV (clocks per bit).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- bus_data  inout  DATA_WIDTH  shared data bus. Driven only during a decoded read, else high-Z.
- bus_addr  in  ADDR_WIDTH  bus address.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe.
- uart_txd  out  1  serial output, idle high.
- busy  out  1  high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Register map, word offsets from START_ADDRESS:
  - +0 TXDATA: write only. Reads return 0.
  - +1 STATUS: read, plus write-to-clear.
  - +2 BAUD_DIV: read/write, 16 bits.
- Addresses outside the 3-word window: the block is invisible and bus_data stays Z.
- Reads are combinational: bus_data = register value while read && address hit, else Z. No read side effects.
- Writes are sampled on the rising clk edge with write && address hit. Only bus_data[7:0] is used for TXDATA.
- TXDATA write when FIFO not full: the byte is pushed and becomes visible in count next cycle.
- TXDATA write when FIFO full: the byte is dropped and sticky overflow is set.
- STATUS layout:
  - bit0 full.
  - bit1 empty.
  - bit2 shifter active.
  - bit3 overflow (sticky).
  - bits[7:4] FIFO count (saturates display at 15).
  - other bits 0.
- Any write to STATUS clears overflow. If an overflowing TXDATA write occurs in the same cycle, set wins. (Only possible with distinct addresses; N/A on a single bus, noted for completeness.)
- BAUD_DIV write: values <2 are clamped to 2. The divisor is latched into the shifter only at frame start; a mid-frame write does not disturb the current frame.
- Shifter FSM:
  - IDLE: uart_txd=1. If FIFO non-empty, pop a byte, latch the divisor, go to START.
  - START: uart_txd=0 for div clocks.
  - DATA: 8 bits LSB first, each div clocks.
  - PARITY: only with the optional feature enabled.
  - STOP: uart_txd=1 for div clocks, then IDLE.
- Back-to-back frames: from STOP, an IDLE with a non-empty FIFO enters START on the next clock. Gap is exactly one clock of idle-high.
- First-byte latency: START begins on the 2nd clock after the accepting write edge (one cycle for FIFO write, one for pop).
- Simultaneous push and pop with FIFO full: the pop frees a slot, so the push is accepted (no overflow).
- Reset values:
  - uart_txd=1, busy=0.
  - FIFO empty, overflow=0.
  - BAUD_DIV=CLK_DIV_DEFAULT.
  - FSM=IDLE, bus_data=Z.
- Reset asserted mid-frame: the frame is aborted, uart_txd goes high on the next edge, and FIFO contents are discarded.

Optional Feature:
- UART_TX_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between DATA and STOP, making each frame 11 bit-times. STATUS bit8 reads 1 to report the feature.
  - Undefined: 8N1, 10 bit-times per frame, no PARITY state, STATUS bit8 reads 0.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Register offsets OFF_TXDATA=0, OFF_STATUS=1, OFF_BAUD=2.
  - STATUS bit indices.
  - MIN_BAUD_DIV=2.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth.
- Bus decode, registers and FSM stay in uart_tx_mmio.

Test Plan:
- Reset, then read +1 → STATUS=16'h0002; read +2 → 434; uart_txd=1; busy=0; bus_data Z when read targets START_ADDRESS+3.
- BAUD_DIV=4, write 8'hA5 to +0 → uart_txd low starting at edge 2 after the write, for 4 clocks. Then data bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high for 4 clocks; busy falls after stop.
- BAUD_DIV=2, write 9 bytes in consecutive cycles → 9th write overflows only if the shifter has not popped; STATUS bit3=1 with count=8. Writing +1 clears bit3.
- Write 8'h11 and 8'h22 back-to-back → second START occurs exactly one idle clock after the first STOP ends.
- Mid-frame write BAUD_DIV=8 while div=4 → the current frame keeps 4 clocks/bit; the next frame uses 8. Writing BAUD_DIV=1 reads back 2.
- Assert reset (low) during DATA of byte 8'h0F → uart_txd=1 on the next edge, STATUS=16'h0002 after release; with UART_TX_PARITY_EN, byte 8'h07 sends parity bit 1 and 8'h03 sends 0.
